bus_burst_slave: RTL and testbench
==================================

# bus_burst_slave

Word-addressed on-chip SRAM that acts as a burst-capable slave on the shared system bus. It is the downstream target of the `ramDmaCi` DMA bus master and of any other bus master. It decodes a begin-transaction beat, checks the address range, and then does one of two things: streams read bursts back to the master, or accepts write bursts from it with optional periodic back-pressure through `busyOut`. The periodic stall lets DMA stall/resume paths be exercised in simulation and on FPGA.

## Interface
Parameters:
- `baseAddress`, 32'h0000_0000: byte address of word 0; must be aligned to `4*sizeWords`.
- `addrBits`, 10: log2 of the memory depth; `sizeWords = 2**addrBits`.
- `readLatency`, 1: idle cycles between the begin beat and the first read data; legal range 1..15.
- `writeStallInterval`, 0: when nonzero, `busyOut` is raised for 2 cycles after every N accepted write words. 0 disables stalls.

Ports:
- `clock`  in  1  system clock. One clock; all logic rises on `posedge clock`.
- `reset`  in  1  synchronous, active-high reset.
- `beginTransactionIn`  in  1  first beat of a transaction.
- `addressDataIn`  in  32  byte address on the begin beat; write data afterwards.
- `readNotWriteIn`  in  1  sampled on the begin beat; 1 = read.
- `burstSizeIn`  in  8  sampled on the begin beat; number of words = value + 1.
- `byteEnablesIn`  in  4  sampled on the begin beat; applies to every write word of the burst.
- `dataValidIn`  in  1  write word present on `addressDataIn`.
- `endTransactionIn`  in  1  master terminates a write burst.
- `addressDataOut`  out  32  read data. Held at 0 whenever `dataValidOut` = 0.
- `dataValidOut`  out  1  read word valid.
- `endTransactionOut`  out  1  one-cycle pulse closing a read burst.
- `busErrorOut`  out  1  one-cycle pulse for an address or burst out of range.
- `busyOut`  out  1  write back-pressure.

## Operation
- States: `IDLE`, `ERROR`, `READ_WAIT`, `READ_DATA`, `READ_END`, `WRITE`.
- Begin handling: `beginTransactionIn` is honoured only in `IDLE`; in every other state it is ignored.
- Latching on begin: word index = `(addr - baseAddress) >> 2`. `addr[1:0]` is ignored. Count = `burstSizeIn + 1` (9-bit, 1..256). `byteEnablesIn` and `readNotWriteIn` are also latched.
- Range check: the transaction is valid only if `baseAddress <= addr` and `index + count <= sizeWords`. The comparison uses 33-bit arithmetic, with no wrap. A transaction that fails the check goes to `ERROR`.
- `ERROR`: `busErrorOut` = 1 for exactly one cycle, then `IDLE`. No RAM access takes place, and any write data on the bus is ignored.
- `READ_WAIT`: counts `readLatency - 1` cycles, with the synchronous RAM read of word `index` issued on the last one. Then `READ_DATA`.
- `READ_DATA`: `dataValidOut` = 1 on `count` consecutive cycles, carrying `mem[index]`, `mem[index+1]`, and so on. There are no gaps. Then `READ_END`.
- `READ_END`: `endTransactionOut` = 1 for one cycle, with `dataValidOut` = 0. Then `IDLE`.
- `WRITE`, word acceptance: a word is accepted when `dataValidIn & ~busyOut`. Accepted bytes are written where the latched `byteEnables` bit = 1. Index and accepted-word counter then increment.
- `WRITE`, overflow: words beyond `count` are ignored.
- `WRITE`, exit: `endTransactionIn` returns the block to `IDLE` in the next cycle, whether or not all words have arrived. Partial writes are kept.
- Stall: when `writeStallInterval = N` > 0, `busyOut` = 1 for the 2 cycles following each Nth accepted word. `busyOut` is 0 in all other states.
- Reset: all outputs = 0, state = `IDLE`, counters cleared. RAM contents are unaffected.
- Reset mid-burst: the burst is aborted with no further beats and no end pulse.

## Timing
- A begin beat is sampled at edge E0.
- Read latency: the first `dataValidOut` is visible from E0 + `readLatency`. With `readLatency=1`, data appears in the cycle right after the begin beat.
- The read `endTransactionOut` is visible `count` cycles after the first data beat.
- `busErrorOut` is visible in the cycle right after the begin beat.
- Write data may arrive from the cycle after the begin beat.
- All outputs are registered. There is no combinational path from any input to any output.
- A new begin beat can be accepted in the cycle after `READ_END`, after `ERROR`, or after the write `IDLE` return.
- Throughput: one word per cycle in both directions when no stalls occur.

## Test plan
- Write burst: `baseAddress=0`, begin to addr 0x40 with `burstSizeIn=3`, `byteEnables=4'hF`, write data 10, 20, 30, 40, then `endTransactionIn`. Read burst of the same range → `dataValidOut` carries 10, 20, 30, 40 on 4 consecutive cycles, then one `endTransactionOut` cycle.
- Read latency: `readLatency=3`, `burstSizeIn=0` at 0x40 → `dataValidOut` rises exactly 3 cycles after the begin beat with value 10.
- Byte enables: write 0xAABBCCDD with `byteEnables=4'b0101` over word 0x11223344 → reads back 0x11BB33DD.
- Range errors:
  - Begin at 0xFFC with `addrBits=10` and `burstSizeIn=1` → one-cycle `busErrorOut`, no data beats, memory unchanged.
  - Begin at exactly 0xFFC with `burstSizeIn=0` → valid, no error.
- Stall: `writeStallInterval=2`, 6-word burst → `busyOut` high for 2 cycles after words 2 and 4. Words held during the stall are written exactly once. All 6 words read back correct.
- Reset mid-read: assert `reset` during the 2nd beat of a 4-word read → all outputs 0 next cycle. A following begin is serviced normally, and memory is intact.

Source files
------------

// File: rtl/bus_burst_slave.sv
`default_nettype none
// ============================================================================
//  Module   : bus_burst_slave
//  Purpose  : Word-addressed SRAM bus slave with burst reads, byte-enabled
//             burst writes and optional periodic write back-pressure.
//  Revision : 1.0  initial release
// ============================================================================
module bus_burst_slave #(
    parameter logic [31:0] baseAddress        = 32'h0000_0000,
    parameter int unsigned addrBits           = 10,
    parameter int unsigned readLatency        = 1,
    parameter int unsigned writeStallInterval = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic        readNotWriteIn,
    input  logic [7:0]  burstSizeIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut,
    output logic        busyOut
);
    localparam int unsigned c_DEPTH      = 1 << addrBits;
    localparam logic [32:0] c_SIZE_WORDS = 33'd1 << addrBits;
    localparam logic [3:0]  c_WAIT_INIT  = 4'(readLatency - 2);
    localparam logic [31:0] c_STALL_N    = 32'(writeStallInterval);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ERROR     = 3'd1,
        S_READ_WAIT = 3'd2,
        S_READ_DATA = 3'd3,
        S_READ_END  = 3'd4,
        S_WRITE     = 3'd5
    } state_t;

    logic [31:0] mem_q [c_DEPTH];

    state_t               state_q, state_d;
    logic [addrBits-1:0]  idx_q, idx_d;
    logic [8:0]           remain_q, remain_d;
    logic [3:0]           wait_q, wait_d;
    logic [3:0]           be_q, be_d;
    logic [31:0]          stallCnt_q, stallCnt_d;
    logic                 stallLeft_q, stallLeft_d;
    logic [31:0]          dataOut_q;
    logic                 dvOut_q, dvOut_d;
    logic                 endOut_q, endOut_d;
    logic                 errOut_q, errOut_d;
    logic                 busy_q, busy_d;

    logic                 w_rdEn, w_wrEn;
    logic [addrBits-1:0]  w_rdIdx;
    logic [32:0]          w_offset;
    logic [8:0]           w_count;
    logic [addrBits-1:0]  w_beginIdx;
    logic                 w_inRange;
    logic                 w_unused;

    // 33-bit offset so the end-of-range test cannot wrap around 2^32
    assign w_offset   = {1'b0, addressDataIn} - {1'b0, baseAddress};
    assign w_count    = {1'b0, burstSizeIn} + 9'd1;
    assign w_beginIdx = w_offset[addrBits+1:2];
    assign w_inRange  = (addressDataIn >= baseAddress) &&
                        (({3'b0, w_offset[31:2]} + {24'b0, w_count}) <= c_SIZE_WORDS);
    assign w_unused   = ^{w_offset[32], w_offset[1:0], readNotWriteIn & 1'b0};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        remain_d    = remain_q;
        wait_d      = wait_q;
        be_d        = be_q;
        stallCnt_d  = stallCnt_q;
        stallLeft_d = stallLeft_q;
        dvOut_d     = 1'b0;
        endOut_d    = 1'b0;
        errOut_d    = 1'b0;
        busy_d      = 1'b0;
        w_rdEn      = 1'b0;
        w_rdIdx     = idx_q;
        w_wrEn      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (beginTransactionIn) begin
                    be_d        = byteEnablesIn;
                    idx_d       = w_beginIdx;
                    remain_d    = w_count;
                    stallCnt_d  = '0;
                    stallLeft_d = 1'b0;
                    if (!w_inRange) begin
                        state_d  = S_ERROR;
                        errOut_d = 1'b1;
                    end else if (readNotWriteIn) begin
                        if (readLatency <= 1) begin
                            state_d  = S_READ_DATA;
                            dvOut_d  = 1'b1;
                            w_rdEn   = 1'b1;
                            w_rdIdx  = w_beginIdx;
                            idx_d    = w_beginIdx + 1'b1;
                            remain_d = w_count - 9'd1;
                        end else begin
                            state_d = S_READ_WAIT;
                            wait_d  = c_WAIT_INIT;
                        end
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_ERROR: state_d = S_IDLE;
            S_READ_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d  = S_READ_DATA;
                    dvOut_d  = 1'b1;
                    w_rdEn   = 1'b1;
                    idx_d    = idx_q + 1'b1;
                    remain_d = remain_q - 9'd1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_READ_DATA: begin
                // remain_q counts beats still owed after the one now on the bus
                if (remain_q == 9'd0) begin
                    state_d  = S_READ_END;
                    endOut_d = 1'b1;
                end else begin
                    dvOut_d  = 1'b1;
                    w_rdEn   = 1'b1;
                    idx_d    = idx_q + 1'b1;
                    remain_d = remain_q - 9'd1;
                end
            end
            S_READ_END: state_d = S_IDLE;
            S_WRITE: begin
                if (busy_q) begin
                    if (stallLeft_q) begin
                        busy_d      = 1'b1;
                        stallLeft_d = 1'b0;
                    end
                end else if (dataValidIn && (remain_q != 9'd0)) begin
                    w_wrEn   = 1'b1;
                    idx_d    = idx_q + 1'b1;
                    remain_d = remain_q - 9'd1;
                    if (c_STALL_N != 32'd0) begin
                        if (stallCnt_q + 32'd1 == c_STALL_N) begin
                            stallCnt_d  = '0;
                            busy_d      = 1'b1;
                            stallLeft_d = 1'b1;
                        end else begin
                            stallCnt_d = stallCnt_q + 32'd1;
                        end
                    end
                end
                if (endTransactionIn) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            remain_q    <= '0;
            wait_q      <= '0;
            be_q        <= '0;
            stallCnt_q  <= '0;
            stallLeft_q <= 1'b0;
            dataOut_q   <= '0;
            dvOut_q     <= 1'b0;
            endOut_q    <= 1'b0;
            errOut_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            remain_q    <= remain_d;
            wait_q      <= wait_d;
            be_q        <= be_d;
            stallCnt_q  <= stallCnt_d;
            stallLeft_q <= stallLeft_d;
            dataOut_q   <= w_rdEn ? mem_q[w_rdIdx] : 32'd0;
            dvOut_q     <= dvOut_d;
            endOut_q    <= endOut_d;
            errOut_q    <= errOut_d;
            busy_q      <= busy_d;
        end
    end

    // RAM contents survive reset; only the write strobe is suppressed
    always_ff @(posedge clock) begin
        if (w_wrEn && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= addressDataIn[8*b +: 8];
                end
            end
        end
    end

    assign addressDataOut    = dataOut_q;
    assign dataValidOut      = dvOut_q;
    assign endTransactionOut = endOut_q;
    assign busErrorOut       = errOut_q;
    assign busyOut           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_burst_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_burst_slave
//  Purpose  : Directed self-checking bench; instance A (latency 1, no stall),
//             instance B (latency 3, stall every 2 words).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_burst_slave;
    logic        clock;
    logic        reset;
    logic        beginT [2];
    logic [31:0] adIn   [2];
    logic        rnw    [2];
    logic [7:0]  bsz    [2];
    logic [3:0]  ben    [2];
    logic        dvIn   [2];
    logic        endIn  [2];
    logic [31:0] adOut  [2];
    logic        dvOut  [2];
    logic        endOut [2];
    logic        errOut [2];
    logic        busyO  [2];

    logic [31:0] vec   [8];
    int          stall [8];
    int          n_chk;
    int          n_err;

    bus_burst_slave #(
        .baseAddress(32'h0), .addrBits(10), .readLatency(1), .writeStallInterval(0)
    ) u_dut_a (
        .clock(clock), .reset(reset),
        .beginTransactionIn(beginT[0]), .addressDataIn(adIn[0]), .readNotWriteIn(rnw[0]),
        .burstSizeIn(bsz[0]), .byteEnablesIn(ben[0]), .dataValidIn(dvIn[0]),
        .endTransactionIn(endIn[0]), .addressDataOut(adOut[0]), .dataValidOut(dvOut[0]),
        .endTransactionOut(endOut[0]), .busErrorOut(errOut[0]), .busyOut(busyO[0])
    );

    bus_burst_slave #(
        .baseAddress(32'h0), .addrBits(10), .readLatency(3), .writeStallInterval(2)
    ) u_dut_b (
        .clock(clock), .reset(reset),
        .beginTransactionIn(beginT[1]), .addressDataIn(adIn[1]), .readNotWriteIn(rnw[1]),
        .burstSizeIn(bsz[1]), .byteEnablesIn(ben[1]), .dataValidIn(dvIn[1]),
        .endTransactionIn(endIn[1]), .addressDataOut(adOut[1]), .dataValidOut(dvOut[1]),
        .endTransactionOut(endOut[1]), .busErrorOut(errOut[1]), .busyOut(busyO[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int d);
        return {28'd0, adOut[d], dvOut[d], endOut[d], errOut[d], busyO[d]};
    endfunction

    task automatic wr_burst(input int d, input string tag, input logic [31:0] addr,
                            input int n, input logic [3:0] be);
        int waits;
        beginT[d] = 1'b1; adIn[d] = addr; rnw[d] = 1'b0; bsz[d] = 8'(n - 1); ben[d] = be;
        tick();
        beginT[d] = 1'b0;
        check($sformatf("%s_noerr", tag), {63'd0, errOut[d]}, 64'd0);
        for (int k = 0; k < n; k++) begin
            dvIn[d] = 1'b1;
            adIn[d] = vec[k];
            waits = 0;
            while (busyO[d] && waits < 8) begin
                tick();
                waits++;
            end
            tick();
            stall[k] = waits;
        end
        dvIn[d] = 1'b0; endIn[d] = 1'b1;
        tick();
        endIn[d] = 1'b0; adIn[d] = 32'd0;
    endtask

    task automatic rd_burst(input int d, input string tag, input logic [31:0] addr,
                            input int n, input int lat);
        int seen;
        beginT[d] = 1'b1; adIn[d] = addr; rnw[d] = 1'b1; bsz[d] = 8'(n - 1); ben[d] = 4'h0;
        tick();
        beginT[d] = 1'b0; adIn[d] = 32'd0;
        seen = 1;
        while (!dvOut[d] && seen < 20) begin
            tick();
            seen++;
        end
        check($sformatf("%s_lat", tag), 64'(seen), 64'(lat));
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_beat%0d", tag, k), {31'd0, dvOut[d], adOut[d]}, {32'd1, vec[k]});
            tick();
        end
        check($sformatf("%s_end", tag), outs(d), 64'h4);
        tick();
        check($sformatf("%s_idle", tag), outs(d), 64'h0);
    endtask

    task automatic err_probe(input int d, input string tag, input logic [31:0] addr,
                             input logic [7:0] bs, input logic r);
        beginT[d] = 1'b1; adIn[d] = addr; rnw[d] = r; bsz[d] = bs; ben[d] = 4'hF;
        tick();
        beginT[d] = 1'b0; dvIn[d] = 1'b1; adIn[d] = 32'hDEAD_BEEF;
        check($sformatf("%s_err", tag), outs(d), 64'h2);
        tick();
        dvIn[d] = 1'b0; adIn[d] = 32'd0;
        check($sformatf("%s_clr", tag), outs(d), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int d = 0; d < 2; d++) begin
            beginT[d] = 1'b0; adIn[d] = 32'd0; rnw[d] = 1'b0; bsz[d] = 8'd0;
            ben[d] = 4'h0; dvIn[d] = 1'b0; endIn[d] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) tick();
        check("rst_a", outs(0), 64'h0);
        check("rst_b", outs(1), 64'h0);
        reset = 1'b0;
        tick();

        // Four-word write then read-back on the no-stall instance
        vec[0] = 32'd10; vec[1] = 32'd20; vec[2] = 32'd30; vec[3] = 32'd40;
        wr_burst(0, "a_wr", 32'h40, 4, 4'hF);
        check("a_nostall", 64'(stall[0] + stall[1] + stall[2] + stall[3]), 64'd0);
        rd_burst(0, "a_rd", 32'h40, 4, 1);

        // Same data into B; word 3 waits out the stall after word 2
        wr_burst(1, "b_wr", 32'h40, 4, 4'hF);
        check("b_wr_stall", 64'(stall[2]), 64'd2);
        rd_burst(1, "b_lat", 32'h40, 1, 3);

        // Byte enables 0101 over 0x11223344
        vec[0] = 32'h1122_3344;
        wr_burst(0, "a_be0", 32'h80, 1, 4'hF);
        vec[0] = 32'hAABB_CCDD;
        wr_burst(0, "a_be1", 32'h80, 1, 4'b0101);
        vec[0] = 32'h11BB_33DD;
        rd_burst(0, "a_be", 32'h80, 1, 1);

        // Range boundary: last word is legal, one past it is not
        vec[0] = 32'hCAFE_F00D;
        wr_burst(0, "a_top", 32'hFFC, 1, 4'hF);
        err_probe(0, "a_ewr", 32'hFFC, 8'd1, 1'b0);
        err_probe(0, "a_erd", 32'hFFC, 8'd1, 1'b1);
        err_probe(0, "a_ebig", 32'hF00, 8'd255, 1'b1);
        err_probe(0, "a_eout", 32'h1000, 8'd0, 1'b0);
        rd_burst(0, "a_top_rd", 32'hFFC, 1, 1);

        // Six-word write with stalls after words 2 and 4
        for (int k = 0; k < 6; k++) vec[k] = 32'h101 + 32'(k);
        wr_burst(1, "b_st", 32'h100, 6, 4'hF);
        for (int k = 0; k < 6; k++)
            check($sformatf("b_st_wait%0d", k), 64'(stall[k]), (k == 2 || k == 4) ? 64'd2 : 64'd0);
        rd_burst(1, "b_st_rd", 32'h100, 6, 3);

        // Reset during the second beat of a four-word read
        vec[0] = 32'd10; vec[1] = 32'd20; vec[2] = 32'd30; vec[3] = 32'd40;
        beginT[0] = 1'b1; adIn[0] = 32'h40; rnw[0] = 1'b1; bsz[0] = 8'd3;
        tick();
        beginT[0] = 1'b0; adIn[0] = 32'd0;
        check("mr_beat0", {31'd0, dvOut[0], adOut[0]}, {32'd1, 32'd10});
        tick();
        check("mr_beat1", {31'd0, dvOut[0], adOut[0]}, {32'd1, 32'd20});
        reset = 1'b1;
        tick();
        check("mr_rst", outs(0), 64'h0);
        reset = 1'b0;
        tick();
        check("mr_quiet", outs(0), 64'h0);
        rd_burst(0, "mr_rd", 32'h40, 4, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
